// File: rtl/seasynth_mem_pkg.sv
// Shared constants and FSM encoding for the scratch-RAM clients.
// Default RAM geometry lives here so RAM and readers agree on it.
package seasynth_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ram_rd_addr_gen.sv
// Address register and remaining-word counter for the RAM stream reader.
// load restarts a block; advance steps the address (mod 2**AW) and counts one word off.
module ram_rd_addr_gen
    import seasynth_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [ADDR_WIDTH-1:0] step,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= len;
        end else if (advance) begin
            // Address sum truncates to AW bits, giving the wrap to address 0.
            addr      <= addr + step;
            remaining <= remaining - ONE;
        end
    end

    assign last  = (remaining == ONE);
    assign empty = (remaining == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a block of scratch-RAM words out on a valid/ready port, tagging the final word.
// Optional RAM_STREAM_STRIDE_EN adds a stride input; otherwise addresses step by 1.
module ram_stream_reader
    import seasynth_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef RAM_STREAM_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    // Handshake: a beat transfers on a cycle where m_valid && m_ready; once raised,
    // m_valid and m_data/m_last hold until that transfer happens.

    rd_state_t             state;
    logic                  ag_load;
    logic                  ag_last;
    logic                  ag_empty;
    logic                  load_fire;
    logic [ADDR_WIDTH-1:0] step;

`ifdef RAM_STREAM_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_q <= '0;
        end else if (state == IDLE && start) begin
            stride_q <= stride;
        end
    end

    assign step = stride_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    assign ag_load   = (state == IDLE) && start && (len != '0);
    assign load_fire = (state == STREAM) && !ag_empty && (!m_valid || m_ready);

    ram_rd_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ag_load),
        .base   (base_addr),
        .len    (len),
        .step   (step),
        .advance(load_fire),
        .addr   (r_addr),
        .last   (ag_last),
        .empty  (ag_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            busy  <= 1'b1;
                            state <= STREAM;
                        end else begin
                            // Empty block: complete immediately without any beats.
                            done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (load_fire) begin
                        m_data  <= ram_data;
                        m_valid <= 1'b1;
                        m_last  <= ag_last;
                        if (ag_last) begin
                            state <= DRAIN;
                        end
                    end else if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: RAM model, scoreboard queue and beat monitor.
// Build with RAM_STREAM_STRIDE_EN defined to add the stride case.
module tb_ram_stream_reader;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] ram_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef RAM_STREAM_STRIDE_EN
    logic [AW-1:0] stride;
`endif

    logic [DW-1:0] ram [0:(1<<AW)-1];
    assign ram_data = ram[r_addr];

    always #5 clk = ~clk;

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
`ifdef RAM_STREAM_STRIDE_EN
        .stride   (stride),
`endif
        .busy     (busy),
        .done     (done),
        .r_addr   (r_addr),
        .ram_data (ram_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // m_ready driver: mode 0 holds it high, mode 1 cycles 1,0,0.
    int rdy_mode = 0;
    int rdy_cyc  = 0;
    always @(posedge clk) begin
        #1;
        rdy_cyc = rdy_cyc + 1;
        m_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_cyc % 3) == 0);
    end

    // Monitor: every presented word must equal the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_beat: got data %0h last %0b, required no beat", m_data, m_last);
            end else begin
                check("m_data", 32'(m_data), 32'(exp_q[0][DW-1:0]));
                check("m_last", 32'(m_last), 32'(exp_q[0][DW]));
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Issue a block, optionally poke start mid-block, and wait (bounded) for done.
    task automatic run_block(input string tag, input int base, input int n, input int step,
                             input bit chk_lat, input bit poke);
        int k;
        int first;
        bit got;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i * step) % (1 << AW);
            exp_q.push_back({(i == n - 1), ram[a]});
        end
        base_addr = AW'(base);
        len       = (AW+1)'(n);
`ifdef RAM_STREAM_STRIDE_EN
        stride    = AW'(step);
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        first = 0;
        got = 1'b0;
        while (k < 200 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({tag, "_busy_after_start"}, 32'(busy), 32'(n != 0));
                check({tag, "_no_valid_n1"}, 32'(m_valid), 32'd0);
            end
            if (poke && k == 3) begin
                base_addr = 4'd9;
                len       = 5'd1;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (m_valid && first == 0) first = k;
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (chk_lat) begin
            check({tag, "_done_latency"}, 32'(k), 32'(n == 0 ? 1 : n + 2));
            if (n != 0) check({tag, "_first_valid"}, 32'(first), 32'd2);
        end
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_valid"}, 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stall_found;
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i + 8'h10);
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        m_ready = 1'b1;
`ifdef RAM_STREAM_STRIDE_EN
        stride = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_r_addr", 32'(r_addr), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rdy_mode = 0;
        run_block("t1_basic", 2, 4, 1, 1'b1, 1'b0);

        rdy_mode = 1;
        run_block("t2_backpressure", 2, 4, 1, 1'b0, 1'b1);

        rdy_mode = 0;
        run_block("t3_wrap", 14, 4, 1, 1'b1, 1'b0);
        run_block("t4_len0", 5, 0, 1, 1'b1, 1'b0);
        run_block("t_full_depth", 3, 16, 1, 1'b1, 1'b0);

        // Reset during a stall drops the pending word and suppresses done.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), ram[i]});
        base_addr = 4'd0;
        len = 5'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stall_found = 1'b0;
        for (int i = 0; i < 100 && !stall_found; i++) begin
            @(negedge clk);
            if (m_valid && !m_ready && exp_q.size() < 6) stall_found = 1'b1;
        end
        check("t5_stall_found", 32'(stall_found), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_m_valid", 32'(m_valid), 32'd0);
        check("t5_rst_m_data", 32'(m_data), 32'd0);
        check("t5_rst_m_last", 32'(m_last), 32'd0);
        check("t5_rst_r_addr", 32'(r_addr), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_done_after_rst", 32'(done), 32'd0);
            check("t5_no_valid_after_rst", 32'(m_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        run_block("t5_fresh", 2, 4, 1, 1'b1, 1'b0);

`ifdef RAM_STREAM_STRIDE_EN
        run_block("t6_stride", 1, 3, 3, 1'b1, 1'b0);
        run_block("t6_stride0", 6, 3, 0, 1'b1, 1'b0);
        run_block("t6_stride_wrap", 13, 3, 5, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
